retire_trace_buffer: RTL
========================

Name: retire_trace_buffer

Overview:
- Sits directly downstream of the core's write-back/retire outputs: pc, instruction, rd address/data, stall.
- Captures one trace entry per retired instruction into a DEPTH-entry FIFO and drains it to a trace sink over valid/ready.
- When the sink is slow, retirements are dropped, counted, and later reported as a single in-band GAP entry, so the sink always knows where the trace is discontinuous.

Parameters:
- XLEN, 32, data/pc/instruction width (taken from riscv_pkg).
- DEPTH, 16, FIFO entries; power of two, >= 2.
- DROP_W, 16, width of the dropped-retirement counter.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- clear_i  in  1  synchronous flush: empties FIFO, clears counters/flags.
- ret_valid_i  in  1  an instruction retires this cycle (core not stalled, valid WB slot).
- ret_pc_i  in  XLEN  retiring pc.
- ret_instr_i  in  XLEN  retiring instruction word.
- ret_rd_addr_i  in  5  rd written; 0 = no register write.
- ret_rd_data_i  in  XLEN  rd write data.
- trace_valid_o  out  1  head entry available.
- trace_ready_i  in  1  sink accepts head entry.
- trace_kind_o  out  trace_kind_e  TR_RETIRE or TR_GAP.
- trace_pc_o  out  XLEN  head pc (GAP: 0).
- trace_instr_o  out  XLEN  head instruction (GAP: zero-extended drop count).
- trace_rd_addr_o  out  5  head rd (GAP: 0).
- trace_rd_data_o  out  XLEN  head rd data (GAP: 0).
- level_o  out  $clog2(DEPTH)+1  current occupancy.
- overflow_o  out  1  sticky: at least one drop since reset/clear.

Behaviour:
- Reset and clear: pointers, level_o and drop counter go to 0; state NORMAL; overflow_o=0; trace_valid_o=0. Payload outputs are don't-care while trace_valid_o=0. clear_i has priority over push and pop in the same cycle.
- FIFO: first-word-fall-through. Head fields are driven from the storage at rd_ptr, with no output register.
- Latency: a push in cycle N is visible at trace_valid_o in cycle N+1. There is no same-cycle bypass, including when the FIFO is empty.
- Pop: occurs when trace_valid_o && trace_ready_i.
- Space: the FIFO has space this cycle if level_o < DEPTH, or a pop occurs this cycle. Push and pop in the same cycle are both honoured when full; level is unchanged.
- Pointers wrap modulo DEPTH. level_o = pushes minus pops, range 0..DEPTH.
- Drop counter saturates at 2^DROP_W-1.
- State machine:
  - NORMAL: ret_valid_i with space -> push TR_RETIRE. ret_valid_i without space -> drop; drop counter = 1, overflow_o=1, go to GAP_PENDING.
  - GAP_PENDING, no space: each ret_valid_i increments the drop counter (saturating).
  - GAP_PENDING, space: push a TR_GAP entry whose payload = drop counter, +1 if ret_valid_i this cycle (that retirement is also dropped, saturating). Then drop counter = 0 and go to NORMAL. The GAP entry always wins over a same-cycle retirement.
- No TR_RETIRE entry is ever pushed while in GAP_PENDING.
- ret_* inputs are sampled only when ret_valid_i=1.
- Mid-operation reset or clear discards all entries, including a pending GAP; no GAP entry is emitted for them.
- The sink may hold trace_ready_i high indefinitely. Head fields must stay stable while trace_valid_o=1 and trace_ready_i=0.

Optional Feature:
- Macro: TRACE_SEQ_NUM_EN.
- Defined:
  - Adds output port trace_seq_o (32 bits) and a 32-bit retirement sequence counter, reset/cleared to 0.
  - The counter increments on every ret_valid_i, whether the retirement is pushed or dropped, wrapping at 2^32.
  - Each TR_RETIRE entry stores the counter value before the increment. A GAP entry stores the sequence number of the first dropped retirement.
  - The sink can therefore cross-check GAP counts against sequence numbers.
- Undefined: the port, counter and storage column are absent; all other behaviour is identical.

Decomposition:
- riscv_pkg gains:
  - typedef enum trace_kind_e {TR_RETIRE, TR_GAP}.
  - typedef struct packed trace_entry_t {kind, pc, instr, rd_addr, rd_data}.
  - The GAP_PENDING/NORMAL state enum.
- One sub-module, trace_fifo: parameterised FWFT storage, pointers and level; push/pop/clear inputs.
- Drop/GAP FSM and push muxing stay in retire_trace_buffer.

Test Plan:
- Basic flow: reset, trace_ready_i=1; 5 retirements pc=0x0,0x4..0x10, rd=1..5 -> 5 TR_RETIRE entries in order, each one cycle after its retirement; level_o returns to 0.
- Fill/full: DEPTH=16, trace_ready_i=0, 16 retirements -> level_o=16, overflow_o=0. Then one push plus one pop in the same cycle -> level_o stays 16, no drop.
- Overflow/GAP: with FIFO full, 3 further retirements; then trace_ready_i=1 while ret_valid_i=1 on the first free cycle -> one TR_GAP entry with trace_instr_o=4, following the 16 retirements; overflow_o=1; subsequent retirements are TR_RETIRE.
- Saturation: DROP_W=4, 20 drops -> GAP payload=15.
- Clear/reset mid-stream: 7 entries queued plus GAP_PENDING, assert clear_i together with ret_valid_i and trace_ready_i -> next cycle level_o=0, trace_valid_o=0, overflow_o=0, no GAP entry emitted. Repeat with rst_i -> same result.
- TRACE_SEQ_NUM_EN: 10 retirements with drops at 5 and 6 -> trace_seq_o sequence 0,1,2,3,4, GAP(seq=5, count=2), 7,8,9.

Source files
------------

// File: rtl/retire_trace_buffer_pkg.sv
// Shared types for the retire trace buffer: entry layout, entry kinds and drop/GAP FSM states.
package retire_trace_buffer_pkg;

  localparam int XLEN  = 32;
  localparam int SEQ_W = 32;

  typedef enum logic {
    TR_RETIRE = 1'b0,
    TR_GAP    = 1'b1
  } trace_kind_e;

  typedef struct packed {
    trace_kind_e     kind;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data;
  } trace_entry_t;

  typedef enum logic {
    ST_NORMAL      = 1'b0,
    ST_GAP_PENDING = 1'b1
  } tbuf_state_e;

endpackage

// File: rtl/retire_trace_buffer_fifo.sv
// First-word-fall-through FIFO: head is read straight from storage at rd_ptr, no output register.
module retire_trace_buffer_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_i);
    rd_ptr_d = rd_ptr_q + AW'(pop_i);
    level_d  = level_q + LW'(push_i) - LW'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (level_q != '0);
  assign level_o = level_q;

endmodule

// File: rtl/retire_trace_buffer.sv
// Retire trace capture with drop counting and in-band GAP entries.
// Optional TRACE_SEQ_NUM_EN adds a per-retirement sequence number column and trace_seq_o.
module retire_trace_buffer
  import retire_trace_buffer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   ret_valid_i,
  input  logic [XLEN-1:0]        ret_pc_i,
  input  logic [XLEN-1:0]        ret_instr_i,
  input  logic [4:0]             ret_rd_addr_i,
  input  logic [XLEN-1:0]        ret_rd_data_i,
  output logic                   trace_valid_o,
  input  logic                   trace_ready_i,
  output trace_kind_e            trace_kind_o,
  output logic [XLEN-1:0]        trace_pc_o,
  output logic [XLEN-1:0]        trace_instr_o,
  output logic [4:0]             trace_rd_addr_o,
  output logic [XLEN-1:0]        trace_rd_data_o,
`ifdef TRACE_SEQ_NUM_EN
  output logic [SEQ_W-1:0]       trace_seq_o,
`endif
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int ENT_BITS = $bits(trace_entry_t);
`ifdef TRACE_SEQ_NUM_EN
  localparam int ENT_W = ENT_BITS + SEQ_W;
`else
  localparam int ENT_W = ENT_BITS;
`endif

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] c, input logic inc);
    return (inc && (c != {DROP_W{1'b1}})) ? c + DROP_W'(1) : c;
  endfunction

  tbuf_state_e       state_q, state_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              ovf_q, ovf_d;
  trace_entry_t      push_entry, head_entry;
  logic [ENT_W-1:0]  fifo_din, fifo_dout;
  logic              push, pop, space, fifo_valid;
  logic [LVL_W-1:0]  level;

`ifdef TRACE_SEQ_NUM_EN
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [SEQ_W-1:0]  gap_seq_q, gap_seq_d;
  logic [SEQ_W-1:0]  push_seq;
`endif

  assign pop   = fifo_valid & trace_ready_i;
  assign space = (level < LVL_W'(DEPTH)) | pop;

  // A pending GAP always takes the free slot ahead of any same-cycle retirement.
  always_comb begin
    state_d            = state_q;
    drop_d             = drop_q;
    ovf_d              = ovf_q;
    push               = 1'b0;
    push_entry.kind    = TR_RETIRE;
    push_entry.pc      = ret_pc_i;
    push_entry.instr   = ret_instr_i;
    push_entry.rd_addr = ret_rd_addr_i;
    push_entry.rd_data = ret_rd_data_i;
`ifdef TRACE_SEQ_NUM_EN
    gap_seq_d          = gap_seq_q;
    push_seq           = seq_q;
`endif
    case (state_q)
      ST_NORMAL: begin
        if (ret_valid_i) begin
          if (space) begin
            push = 1'b1;
          end else begin
            drop_d  = DROP_W'(1);
            ovf_d   = 1'b1;
            state_d = ST_GAP_PENDING;
`ifdef TRACE_SEQ_NUM_EN
            gap_seq_d = seq_q;
`endif
          end
        end
      end
      ST_GAP_PENDING: begin
        if (space) begin
          push               = 1'b1;
          push_entry.kind    = TR_GAP;
          push_entry.pc      = '0;
          push_entry.instr   = XLEN'(sat_inc(drop_q, ret_valid_i));
          push_entry.rd_addr = '0;
          push_entry.rd_data = '0;
`ifdef TRACE_SEQ_NUM_EN
          push_seq           = gap_seq_q;
`endif
          drop_d             = '0;
          state_d            = ST_NORMAL;
        end else begin
          drop_d = sat_inc(drop_q, ret_valid_i);
        end
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q <= ST_NORMAL;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef TRACE_SEQ_NUM_EN
  assign seq_d    = seq_q + SEQ_W'(ret_valid_i);
  assign fifo_din = {push_seq, push_entry};

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) seq_q <= '0;
    else                  seq_q <= seq_d;
  end

  always_ff @(posedge clk_i) begin
    gap_seq_q <= gap_seq_d;
  end

  assign trace_seq_o = fifo_dout[ENT_W-1 -: SEQ_W];
`else
  assign fifo_din = push_entry;
`endif

  retire_trace_buffer_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push_i  (push),
    .data_i  (fifo_din),
    .pop_i   (pop),
    .data_o  (fifo_dout),
    .valid_o (fifo_valid),
    .level_o (level)
  );

  assign head_entry      = fifo_dout[ENT_BITS-1:0];
  assign trace_valid_o   = fifo_valid;
  assign trace_kind_o    = head_entry.kind;
  assign trace_pc_o      = head_entry.pc;
  assign trace_instr_o   = head_entry.instr;
  assign trace_rd_addr_o = head_entry.rd_addr;
  assign trace_rd_data_o = head_entry.rd_data;
  assign level_o         = level;
  assign overflow_o      = ovf_q;

endmodule
